// File: rtl/proc_pkg.sv
// proc_pkg: shared opcode/state types and field-width helpers for param_simple_processor
// Contents: op_e (3-bit opcodes), state_e (IDLE/FETCH/EXEC/WB),
//           addr_w (index width of a memory), low_w (width of the shared low
//           instruction field), instr_w (full instruction width).
package proc_pkg;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'd0,
        OP_STORE = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_AND   = 3'd4,
        OP_OR    = 3'd5,
        OP_BEQZ  = 3'd6,
        OP_HALT  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_WB    = 2'd3
    } state_e;

    // A one-entry memory still needs a 1-bit index to keep ports legal.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Low field must hold a memory address, two register selects or a branch target.
    function automatic int low_w(input int rf_depth, input int dm_depth, input int im_depth);
        int m;
        m = addr_w(dm_depth);
        if (2 * addr_w(rf_depth) > m) m = 2 * addr_w(rf_depth);
        if (addr_w(im_depth) > m) m = addr_w(im_depth);
        return m;
    endfunction

    function automatic int instr_w(input int rf_depth, input int dm_depth, input int im_depth);
        return 3 + addr_w(rf_depth) + low_w(rf_depth, dm_depth, im_depth);
    endfunction

endpackage

// File: rtl/proc_regfile.sv
// proc_regfile: DEPTH x DW register file, two combinational read ports plus debug read, one sync write
// Ports: i_clk, i_reset (async, clears all registers), i_we/i_waddr/i_wdata (write),
//        i_raddr_a/o_rdata_a and i_raddr_b/o_rdata_b (operand reads),
//        i_raddr_dbg/o_rdata_dbg (debug read).
module proc_regfile
    import proc_pkg::*;
#(
    parameter int DW    = 4,
    parameter int DEPTH = 8,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    input  logic [AW-1:0] i_raddr_b,
    input  logic [AW-1:0] i_raddr_dbg,
    output logic [DW-1:0] o_rdata_a,
    output logic [DW-1:0] o_rdata_b,
    output logic [DW-1:0] o_rdata_dbg
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a   = r_mem[i_raddr_a];
    assign o_rdata_b   = r_mem[i_raddr_b];
    assign o_rdata_dbg = r_mem[i_raddr_dbg];

endmodule

// File: rtl/param_simple_processor.sv
// param_simple_processor: parametrised multi-cycle LOAD/STORE/ALU/BEQZ/HALT core with internal IM and DM
// Ports: i_clk, i_reset (async, clears everything but IM);
//        i_run_en (free-run level), i_step (single-step pulse), i_ext_exec/i_ext_instr (one external instr);
//        i_im_we/i_im_addr/i_im_wdata (IM load, IDLE only); i_dbg_raddr/o_dbg_rdata (register peek);
//        o_result/o_result_valid (write-back value and pulse), o_carry, o_pc, o_busy, o_halted.
module param_simple_processor
    import proc_pkg::*;
#(
    parameter  int DW       = 4,
    parameter  int RF_DEPTH = 8,
    parameter  int DM_DEPTH = 16,
    parameter  int IM_DEPTH = 16,
    localparam int RA       = addr_w(RF_DEPTH),
    localparam int MA       = addr_w(DM_DEPTH),
    localparam int IA       = addr_w(IM_DEPTH),
    localparam int FW       = low_w(RF_DEPTH, DM_DEPTH, IM_DEPTH),
    localparam int IW       = instr_w(RF_DEPTH, DM_DEPTH, IM_DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_run_en,
    input  logic          i_step,
    input  logic          i_ext_exec,
    input  logic [IW-1:0] i_ext_instr,
    input  logic          i_im_we,
    input  logic [IA-1:0] i_im_addr,
    input  logic [IW-1:0] i_im_wdata,
    input  logic [RA-1:0] i_dbg_raddr,
    output logic [DW-1:0] o_dbg_rdata,
    output logic [DW-1:0] o_result,
    output logic          o_result_valid,
    output logic          o_carry,
    output logic [IA-1:0] o_pc,
    output logic          o_busy,
    output logic          o_halted
);

    state_e        r_state, w_next;
    logic [IW-1:0] r_ir;
    logic [IA-1:0] r_pc;
    logic          r_ext;
    logic          r_taken;
    logic          r_run_block;
    logic          r_halted;
    logic          r_carry;
    logic          r_result_valid;
    logic [DW-1:0] r_result;
    logic [DW-1:0] r_dm [DM_DEPTH];
    logic [IW-1:0] r_im [IM_DEPTH];

    op_e           w_op;
    logic [RA-1:0] w_rd, w_rs1, w_rs2;
    logic [FW-1:0] w_f;
    logic [MA-1:0] w_maddr;
    logic [IA-1:0] w_target, w_pc_inc;
    logic [DW-1:0] w_a, w_b, w_alu;
    logic [DW:0]   w_sum, w_diff;
    logic          w_is_alu, w_run_ok, w_start, w_cont;

    assign w_op     = op_e'(r_ir[IW-1 -: 3]);
    assign w_rd     = r_ir[IW-4 -: RA];
    assign w_f      = r_ir[FW-1:0];
    assign w_maddr  = w_f[MA-1:0];
    assign w_rs1    = w_f[2*RA-1:RA];
    assign w_rs2    = w_f[RA-1:0];
    assign w_target = w_f[IA-1:0];
    assign w_is_alu = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND) || (w_op == OP_OR);

    // Port A serves rs1 for ALU ops and rd for STORE data / BEQZ test.
    proc_regfile #(.DW(DW), .DEPTH(RF_DEPTH), .AW(RA)) u_rf (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_we       (r_result_valid),
        .i_waddr    (w_rd),
        .i_wdata    (r_result),
        .i_raddr_a  (w_is_alu ? w_rs1 : w_rd),
        .i_raddr_b  (w_rs2),
        .i_raddr_dbg(i_dbg_raddr),
        .o_rdata_a  (w_a),
        .o_rdata_b  (w_b),
        .o_rdata_dbg(o_dbg_rdata)
    );

    // Bit DW of the difference is the borrow (rs1 < rs2).
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = {1'b0, w_a} - {1'b0, w_b};
    assign w_alu  = (w_op == OP_ADD) ? w_sum[DW-1:0] :
                    (w_op == OP_SUB) ? w_diff[DW-1:0] :
                    (w_op == OP_AND) ? (w_a & w_b) : (w_a | w_b);

    // After a HALT, run_en must be seen low once before it can start or continue a run.
    assign w_run_ok = i_run_en && !r_run_block;
    assign w_start  = i_ext_exec || w_run_ok || i_step;
    assign w_cont   = !r_ext && w_run_ok && (w_op != OP_HALT);
    assign w_pc_inc = (r_pc == IA'(IM_DEPTH - 1)) ? '0 : r_pc + IA'(1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_start ? S_FETCH : S_IDLE;
            S_FETCH: w_next = S_EXEC;
            S_EXEC:  w_next = S_WB;
            default: w_next = w_cont ? S_FETCH : S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ir           <= '0;
            r_pc           <= '0;
            r_ext          <= 1'b0;
            r_taken        <= 1'b0;
            r_run_block    <= 1'b0;
            r_halted       <= 1'b0;
            r_carry        <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            for (int i = 0; i < DM_DEPTH; i++) r_dm[i] <= '0;
        end else begin
            r_result_valid <= 1'b0;
            if (!i_run_en) r_run_block <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_ext    <= i_ext_exec;
                        r_halted <= 1'b0;
                    end
                end
                S_FETCH: r_ir <= r_ext ? i_ext_instr : r_im[r_pc];
                S_EXEC: begin
                    r_taken <= (w_op == OP_BEQZ) && (w_a == '0);
                    if (w_op == OP_STORE) r_dm[w_maddr] <= w_a;
                    // Result is captured here so it and the DM read data are ready for WB.
                    if ((w_op == OP_LOAD) || w_is_alu) begin
                        r_result       <= (w_op == OP_LOAD) ? r_dm[w_maddr] : w_alu;
                        r_result_valid <= 1'b1;
                    end
                    if (w_op == OP_ADD) r_carry <= w_sum[DW];
                    if (w_op == OP_SUB) r_carry <= w_diff[DW];
                end
                default: begin
                    if (w_op == OP_HALT) begin
                        r_halted    <= 1'b1;
                        r_run_block <= 1'b1;
                    end else if (r_taken) begin
                        r_pc <= w_target;
                    end else if (!r_ext) begin
                        r_pc <= w_pc_inc;
                    end
                end
            endcase
        end
    end

    // Instruction memory keeps its contents through reset.
    always_ff @(posedge i_clk) begin
        if ((r_state == S_IDLE) && i_im_we) r_im[i_im_addr] <= i_im_wdata;
    end

    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_carry        = r_carry;
    assign o_pc           = r_pc;
    assign o_busy         = (r_state != S_IDLE);
    assign o_halted       = r_halted;

endmodule

// File: tb/tb_param_simple_processor.sv
// tb_param_simple_processor: self-checking bench for param_simple_processor at default parameters
module tb_param_simple_processor;

    localparam int DW = 4, RFD = 8, DMD = 16, IMD = 16, RA = 3, IA = 4, FW = 6, IW = 12;

    logic          clk = 1'b0, reset = 1'b1, run_en = 1'b0, step = 1'b0, ext_exec = 1'b0, im_we = 1'b0;
    logic [IW-1:0] ext_instr = '0, im_wdata = '0;
    logic [IA-1:0] im_addr = '0;
    logic [RA-1:0] dbg_raddr = '0;
    logic [DW-1:0] dbg_rdata, result;
    logic          result_valid, carry, busy, halted;
    logic [IA-1:0] pc;

    int total = 0, bad = 0;

    int            m_rf [RFD];
    int            m_dm [DMD];
    int            m_pc, m_result;
    bit            m_carry, m_halt;
    logic [IW-1:0] m_im [IMD];

    bit d_rv, d_c;
    int d_res, n;

    typedef struct {
        logic [IW-1:0] ins;
        bit            v;
        int            res;
        bit            c;
        int            dreg;
        int            dval;
        int            pc;
    } vec_t;
    vec_t tbl [14];

    param_simple_processor dut (
        .i_clk(clk), .i_reset(reset), .i_run_en(run_en), .i_step(step),
        .i_ext_exec(ext_exec), .i_ext_instr(ext_instr),
        .i_im_we(im_we), .i_im_addr(im_addr), .i_im_wdata(im_wdata),
        .i_dbg_raddr(dbg_raddr), .o_dbg_rdata(dbg_rdata),
        .o_result(result), .o_result_valid(result_valid), .o_carry(carry),
        .o_pc(pc), .o_busy(busy), .o_halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] mk(input int op, input int rd, input int f);
        return {op[2:0], rd[RA-1:0], f[FW-1:0]};
    endfunction

    function automatic int rr(input int a, input int b);
        return a * (1 << RA) + b;
    endfunction

    task automatic m_clear;
        for (int i = 0; i < RFD; i++) m_rf[i] = 0;
        for (int i = 0; i < DMD; i++) m_dm[i] = 0;
        m_pc = 0; m_result = 0; m_carry = 0; m_halt = 0;
    endtask

    // Reference semantics of one instruction, straight from the opcode table.
    task automatic m_exec(input logic [IW-1:0] ins, input bit prog, output bit v);
        int op, rd, f, a, b;
        op = int'(ins[IW-1 -: 3]);
        rd = int'(ins[IW-4 -: RA]);
        f  = int'(ins[FW-1:0]);
        a  = m_rf[(f / (1 << RA)) % (1 << RA)];
        b  = m_rf[f % (1 << RA)];
        v  = (op == 0) || (op >= 2 && op <= 5);
        m_halt = (op == 7);
        case (op)
            0: m_result = m_dm[f % DMD];
            1: m_dm[f % DMD] = m_rf[rd];
            2: begin m_result = (a + b) % (1 << DW); m_carry = (a + b) >= (1 << DW); end
            3: begin m_result = (a - b + (1 << DW)) % (1 << DW); m_carry = a < b; end
            4: m_result = a & b;
            5: m_result = a | b;
            default: ;
        endcase
        if (v) m_rf[rd] = m_result;
        if (op == 6 && m_rf[rd] == 0) m_pc = f % IMD;
        else if (prog && op != 7) m_pc = (m_pc + 1) % IMD;
    endtask

    task automatic do_reset;
        reset = 1'b1; run_en = 0; step = 0; ext_exec = 0; im_we = 0;
        tick; tick;
        m_clear;
        reset = 1'b0;
        tick;
    endtask

    task automatic dm_set(input int a, input int v);
        dut.r_dm[a] <= v[DW-1:0];
        m_dm[a] = v;
        tick;
    endtask

    task automatic im_wr(input int a, input logic [IW-1:0] d);
        im_we = 1'b1; im_addr = a[IA-1:0]; im_wdata = d;
        tick;
        im_we = 1'b0;
        m_im[a] = d;
    endtask

    // One started instruction from IDLE: start edge, FETCH, EXEC, sample in WB, back to IDLE.
    task automatic do_one(input logic [IW-1:0] ins, input bit use_step, input bit both,
                          output bit g_rv, output int g_res, output bit g_c);
        logic [IW-1:0] e;
        bit v;
        int rd;
        e = use_step ? m_im[m_pc] : ins;
        ext_instr = ins; ext_exec = !use_step; step = use_step | both;
        tick;
        ext_exec = 0; step = 0;
        chk("start_busy", busy, 1);
        chk("start_halted", halted, 0);
        tick; tick;
        m_exec(e, use_step, v);
        g_rv = result_valid; g_res = int'(result); g_c = carry;
        chk("wb_valid", result_valid, v);
        chk("wb_result", result, m_result);
        chk("wb_carry", carry, m_carry);
        tick;
        chk("end_busy", busy, 0);
        chk("end_pc", pc, m_pc);
        chk("end_halted", halted, m_halt);
        rd = int'(e[IW-4 -: RA]);
        dbg_raddr = rd[RA-1:0];
        #1;
        chk("end_dbg", dbg_rdata, m_rf[rd]);
    endtask

    initial begin
        tbl[0]  = '{mk(0, 1, 3), 1, 5, 0, 1, 5, 0};
        tbl[1]  = '{mk(0, 3, 6), 1, 3, 0, 3, 3, 0};
        tbl[2]  = '{mk(1, 1, 7), 0, 3, 0, 1, 5, 0};
        tbl[3]  = '{mk(0, 4, 7), 1, 5, 0, 4, 5, 0};
        tbl[4]  = '{mk(0, 1, 4), 1, 9, 0, 1, 9, 0};
        tbl[5]  = '{mk(2, 2, rr(1, 1)), 1, 2, 1, 2, 2, 0};
        tbl[6]  = '{mk(3, 5, rr(3, 4)), 1, 14, 1, 5, 14, 0};
        tbl[7]  = '{mk(4, 6, rr(5, 1)), 1, 8, 1, 6, 8, 0};
        tbl[8]  = '{mk(5, 7, rr(3, 4)), 1, 7, 1, 7, 7, 0};
        tbl[9]  = '{mk(3, 0, rr(4, 3)), 1, 2, 0, 0, 2, 0};
        tbl[10] = '{mk(2, 0, rr(0, 3)), 1, 5, 0, 0, 5, 0};
        tbl[11] = '{mk(6, 6, 9), 0, 5, 0, 6, 8, 0};
        tbl[12] = '{mk(3, 2, rr(3, 3)), 1, 0, 0, 2, 0, 0};
        tbl[13] = '{mk(6, 2, 9), 0, 0, 0, 2, 0, 9};

        do_reset;
        chk("rst_result", result, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_carry", carry, 0);
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);

        do_one(mk(0, 1, 3), 0, 0, d_rv, d_res, d_c);
        chk("load_zero", d_res, 0);
        dm_set(3, 5); dm_set(4, 9); dm_set(6, 3);
        for (int i = 0; i < 14; i++) begin
            do_one(tbl[i].ins, 0, 0, d_rv, d_res, d_c);
            chk($sformatf("tbl%0d_valid", i), d_rv, tbl[i].v);
            chk($sformatf("tbl%0d_result", i), d_res, tbl[i].res);
            chk($sformatf("tbl%0d_carry", i), d_c, tbl[i].c);
            chk($sformatf("tbl%0d_pc", i), pc, tbl[i].pc);
            dbg_raddr = tbl[i].dreg[RA-1:0];
            #1;
            chk($sformatf("tbl%0d_dbg", i), dbg_rdata, tbl[i].dval);
        end

        // Free-run loop: 3-cycle cadence, wrap through BEQZ at pc 15 back to 2.
        do_reset;
        dm_set(0, 1);
        im_wr(0, mk(0, 2, 0));
        for (int i = 1; i < 15; i++) im_wr(i, mk(2, 1, rr(1, 2)));
        im_wr(15, mk(6, 3, 2));
        run_en = 1'b1;
        tick;
        for (int k = 0; k < 20; k++) begin
            tick; tick;
            m_exec(m_im[m_pc], 1, d_rv);
            chk($sformatf("run%0d_valid", k), result_valid, d_rv);
            chk($sformatf("run%0d_result", k), result, m_result);
            chk($sformatf("run%0d_carry", k), carry, m_carry);
            if (k == 19) run_en = 1'b0;
            tick;
            chk($sformatf("run%0d_pc", k), pc, m_pc);
            chk($sformatf("run%0d_busy", k), busy, k != 19);
        end

        // HALT at pc 4 with run_en held high.
        do_reset;
        for (int i = 0; i < 4; i++) im_wr(i, mk(5, 0, rr(0, 0)));
        im_wr(4, mk(7, 0, 0));
        run_en = 1'b1;
        tick;
        n = 0;
        while (busy && n < 60) begin tick; n++; end
        chk("halt_reached", n < 60, 1);
        chk("halt_flag", halted, 1);
        chk("halt_pc", pc, 4);
        chk("halt_busy", busy, 0);
        repeat (5) tick;
        chk("halt_no_restart", busy, 0);
        run_en = 1'b0; tick;
        run_en = 1'b1; tick;
        chk("rearm_busy", busy, 1);
        chk("rearm_halted", halted, 0);
        run_en = 1'b0;
        n = 0;
        while (busy && n < 60) begin tick; n++; end
        chk("rehalt_flag", halted, 1);
        chk("rehalt_pc", pc, 4);

        // ext_exec and step in the same cycle: only the external SUB runs.
        m_clear; m_pc = 4; m_halt = 1;
        do_one(mk(3, 6, rr(0, 1)), 0, 1, d_rv, d_res, d_c);
        chk("both_valid", d_rv, 1);

        // IM writes while busy are dropped.
        do_reset;
        im_wr(0, mk(5, 0, rr(0, 0)));
        ext_instr = mk(4, 1, rr(0, 0)); ext_exec = 1'b1;
        tick;
        ext_exec = 1'b0; im_we = 1'b1; im_addr = '0; im_wdata = mk(7, 0, 0);
        tick;
        im_we = 1'b0;
        tick; tick;
        chk("imwe_idle", busy, 0);
        m_exec(mk(4, 1, rr(0, 0)), 0, d_rv);
        do_one('0, 1, 0, d_rv, d_res, d_c);
        chk("imwe_step_valid", d_rv, 1);

        // Reset during EXEC of a STORE aborts it.
        dm_set(2, 7);
        do_one(mk(0, 1, 2), 0, 0, d_rv, d_res, d_c);
        chk("pre_store_load", d_res, 7);
        ext_instr = mk(1, 1, 9); ext_exec = 1'b1;
        tick;
        ext_exec = 1'b0;
        tick;
        reset = 1'b1;
        #1;
        chk("abort_result", result, 0);
        chk("abort_valid", result_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_pc", pc, 0);
        dbg_raddr = 3'd1;
        #1;
        chk("abort_dbg", dbg_rdata, 0);
        reset = 1'b0;
        m_clear;
        tick;
        do_one(mk(0, 2, 9), 0, 0, d_rv, d_res, d_c);

        // Randomized external instructions and stepped programs against the model.
        do_reset;
        for (int i = 0; i < DMD; i++) dm_set(i, int'($urandom_range(0, 15)));
        for (int i = 0; i < 40; i++)
            do_one(mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 63))),
                   0, 0, d_rv, d_res, d_c);
        for (int i = 0; i < IMD; i++)
            im_wr(i, mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 63))));
        for (int i = 0; i < 24; i++) do_one('0, 1, 0, d_rv, d_res, d_c);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_simple_processor.md
# param_simple_processor

Parametrised multi-cycle 4-op-plus-branch processor core: the next generation of the board-level simple processor, with configurable data width, register-file depth, data-memory depth and instruction-memory depth. Executes programs from an internal instruction memory (free-run or single-step) or single external instructions from the switch bank. Sits between the debouncers and the seven-segment display driver; display formatting stays outside this block.

## Interface
- DW, 4: data width (register, memory word, ALU)
- RF_DEPTH, 8: register count; RA = clog2(RF_DEPTH)
- DM_DEPTH, 16: data-memory words; MA = clog2(DM_DEPTH)
- IM_DEPTH, 16: instruction-memory words; IA = clog2(IM_DEPTH)
- Derived IW = 3 + RA + max(MA, 2*RA, IA) (12 at defaults)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state except instruction memory
- run_en  in  1  level: free-run from pc
- step  in  1  one-cycle pulse: execute one instruction at pc
- ext_exec  in  1  one-cycle pulse: execute ext_instr once
- ext_instr  in  IW  external instruction
- im_we  in  1  instruction-memory write strobe
- im_addr  in  IA  write address
- im_wdata  in  IW  write data
- dbg_raddr  in  RA  debug register select
- dbg_rdata  out  DW  RF[dbg_raddr], combinational
- result  out  DW  last written-back value, reset 0
- result_valid  out  1  one-cycle pulse in WB, reset 0
- carry  out  1  carry/borrow of last ADD/SUB, reset 0
- pc  out  IA  program counter, reset 0
- busy  out  1  FSM not IDLE, reset 0
- halted  out  1  sticky HALT flag, reset 0

## Operation
- Fields: op = [IW-1:IW-3]; rd = next RA bits; low field F: MEM addr = F[MA-1:0], rs1 = F[2RA-1:RA], rs2 = F[RA-1:0], branch target = F[IA-1:0].
- Opcodes: 000 LOAD rd<-DM[addr]; 001 STORE DM[addr]<-RF[rd]; 010 ADD; 011 SUB; 100 AND; 101 OR (rd<-rs1 op rs2); 110 BEQZ: if RF[rd]==0, pc<-target; 111 HALT.
- Arithmetic wraps mod 2^DW; carry = bit DW of ADD sum, SUB sets carry=1 on borrow (rs1<rs2); other ops leave carry unchanged.
- FSM IDLE -> FETCH -> EXEC -> WB -> (IDLE or FETCH).
- IDLE start priority: ext_exec > run_en > step. Any accepted start clears halted.
- FETCH: latch IM[pc] (or ext_instr for ext start) into instruction register.
- EXEC: RF read, ALU evaluate, DM write (STORE), DM read issue (LOAD), branch resolve.
- WB: RF write (LOAD/ALU), result updated and result_valid=1 for LOAD/ALU only; pc<-target if branch taken else pc+1 mod IM_DEPTH (program starts only; ext_exec leaves pc except taken BEQZ).
- After WB: FETCH if run_en high and program mode and not HALT; else IDLE.
- HALT: no writes, pc unchanged, halted=1, go IDLE; run_en must fall low before a new run start is accepted (arm on low level). step/ext_exec accepted immediately.
- im_we honoured only in IDLE; ignored when busy. pulses of step/ext_exec while busy are dropped.
- RF and DM contents zero on reset; IM not reset.

## Timing
- Every instruction: 3 cycles (FETCH, EXEC, WB); start edge in IDLE adds 1 cycle; result_valid asserts 3 cycles after the accepted start cycle.
- Free-run throughput: one instruction per 3 cycles, no IDLE between.
- DM read synchronous (issued EXEC, data in WB); RF read combinational; dbg_rdata reflects RF write the cycle after WB.
- Reset asserted mid-instruction: immediate abort, all outputs to reset values, no partial write survives.

## Structure
- Package proc_pkg: opcode enum, FSM state enum, field-width helper functions (RA, MA, IA, IW computation).
- Sub-module proc_regfile (RF_DEPTH x DW, two combinational read ports plus debug read, one sync write, async clear).
- ALU, DM, IM and FSM inside the top.

## Test plan
- Reset, ext_exec LOAD r1<-DM[3] (=0) then STORE/LOAD round trip via IM: write 5 to DM[3] path -> dbg r1 = 5, result_valid pulses.
- ADD r2<-r1+r1 with r1=9 (DW=4) -> r2=2, carry=1; SUB 3-5 -> 14, carry=1.
- Program ADD loop with BEQZ back-branch at pc 15 -> pc wraps to 0 / jumps to target, 3-cycle cadence checked.
- HALT at pc 4 with run_en held high -> halted=1, busy=0, pc=4, no restart until run_en low then high.
- ext_exec and step pulsed same cycle in IDLE -> only ext instruction executes, pc unchanged.
- reset during EXEC of STORE -> DM unchanged (0), all outputs 0; im_we while busy -> IM unchanged.
